// File: rtl/opnd_fifo_bank_pkg.sv
// Shared constants for the operand FIFO bank.
// Lane counts follow the PE array dimensions so both operand edges
// (row and column) size their banks from the same source.
package opnd_fifo_bank_pkg;

  localparam int PE_ARRAY_ROWS       = 32;
  localparam int PE_ARRAY_COLS       = 32;
  localparam int OPND_DATA_WIDTH     = 8;
  localparam int OPND_FIFO_DEPTH     = 32;
  localparam int OPND_SRAM_RD_LAT    = 1;

  // Elaboration-time ceil(log2()) for sizing pointers and counts.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int OPND_FIFO_DEPTH_LOG2 = clog2_f(OPND_FIFO_DEPTH);

endpackage

// File: rtl/opnd_fifo_lane.sv
// Single operand FIFO lane.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   stall          - hold every register this cycle, ignore push/pop
//   clear          - synchronous flush; wins over stall and push/pop
//   push, wr_data  - write wr_data at the tail (already aligned to SRAM data)
//   pop            - read the head; result appears on rd_data next cycle
//   rd_data, valid - registered head element, zero with valid=0 when idle
//   full, empty    - registered status reflecting the post-update count
//   overflow       - combinational pulse: push into a full lane without pop
//   underflow      - combinational pulse: pop from an empty lane
module opnd_fifo_lane
  import opnd_fifo_bank_pkg::*;
#(
  parameter int DATA_WIDTH = OPND_DATA_WIDTH,
  parameter int DEPTH      = OPND_FIFO_DEPTH,
  parameter int DEPTH_LOG2 = OPND_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DEPTH_LOG2-1:0] PTR_LAST   = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  logic active;
  logic do_push;
  logic do_pop;

  // Explicit wrap so non-power-of-two depths also work.
  function automatic logic [DEPTH_LOG2-1:0] next_ptr(input logic [DEPTH_LOG2-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    active    = !stall && !clear;
    do_pop    = active && pop && !empty_q;
    // A pop in the same cycle frees the slot, so a full lane still accepts.
    do_push   = active && push && (!full_q || do_pop);
    overflow  = active && push && full_q && !do_pop;
    // No bypass: an empty lane underflows even if a push arrives alongside.
    underflow = active && pop && empty_q;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    valid_d   = valid_q;
    full_d    = full_q;
    empty_d   = empty_q;

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
      valid_d   = 1'b0;
      full_d    = 1'b0;
      empty_d   = 1'b1;
    end else if (!stall) begin
      // Bubbles must reach the array as zeros.
      rd_data_d = do_pop ? mem_q[rd_ptr_q] : '0;
      valid_d   = do_pop;
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_d = count_q + COUNT_ONE;
      end else if (do_pop && !do_push) begin
        count_d = count_q - COUNT_ONE;
      end
      full_d  = (count_d == COUNT_FULL);
      empty_d = (count_d == '0);
    end
  end

  // Storage is not reset; the cleared pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign rd_data = rd_data_q;
  assign valid   = valid_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/opnd_fifo_bank.sv
// Bank of per-lane operand FIFOs feeding one edge of the PE array.
// Each push buffers one SRAM row (one element per lane); lanes are then
// popped individually so the array receives a skewed, diagonal feed.
// Ports:
//   CLK, RSTn          - clock, asynchronous active-low reset
//   STALL, CLEAR       - freeze the bank / synchronous tile-start flush
//   SRAM_RDATA_in      - SRAM row, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   PUSHEs_in          - per-lane push enables, issued with the SRAM address
//   POPEs_in           - per-lane pop enables
//   DATA_out, VALIDs_out - registered popped element per lane
//   FULLs_out, EMPTYs_out - per-lane status
//   OVERFLOW_ERR_out, UNDERFLOW_ERR_out - sticky error flags
module opnd_fifo_bank
  import opnd_fifo_bank_pkg::*;
#(
  parameter int NUM_LANES       = PE_ARRAY_ROWS,
  parameter int DATA_WIDTH      = OPND_DATA_WIDTH,
  parameter int DEPTH           = OPND_FIFO_DEPTH,
  parameter int DEPTH_LOG2      = clog2_f(DEPTH),
  parameter int SRAM_RD_LATENCY = OPND_SRAM_RD_LAT
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            STALL,
  input  logic                            CLEAR,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] SRAM_RDATA_in,
  input  logic [NUM_LANES-1:0]            PUSHEs_in,
  input  logic [NUM_LANES-1:0]            POPEs_in,
  output logic [NUM_LANES*DATA_WIDTH-1:0] DATA_out,
  output logic [NUM_LANES-1:0]            VALIDs_out,
  output logic [NUM_LANES-1:0]            FULLs_out,
  output logic [NUM_LANES-1:0]            EMPTYs_out,
  output logic                            OVERFLOW_ERR_out,
  output logic                            UNDERFLOW_ERR_out
);

  logic [NUM_LANES-1:0] push_eff;
  logic [NUM_LANES-1:0] ovf_pulse;
  logic [NUM_LANES-1:0] udf_pulse;
  logic                 ovf_err_q, ovf_err_d;
  logic                 udf_err_q, udf_err_d;

  // Delay push enables so the effective push lines up with SRAM read data.
  if (SRAM_RD_LATENCY == 0) begin : g_no_delay
    assign push_eff = PUSHEs_in;
  end else begin : g_delay
    logic [SRAM_RD_LATENCY-1:0][NUM_LANES-1:0] push_pipe_q, push_pipe_d;

    always_comb begin
      push_pipe_d = push_pipe_q;
      if (CLEAR) begin
        push_pipe_d = '0;
      end else if (!STALL) begin
        push_pipe_d[0] = PUSHEs_in;
        for (int s = 1; s < SRAM_RD_LATENCY; s++) begin
          push_pipe_d[s] = push_pipe_q[s-1];
        end
      end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        push_pipe_q <= '0;
      end else begin
        push_pipe_q <= push_pipe_d;
      end
    end

    assign push_eff = push_pipe_q[SRAM_RD_LATENCY-1];
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    opnd_fifo_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_lane (
      .clk       (CLK),
      .rst_n     (RSTn),
      .stall     (STALL),
      .clear     (CLEAR),
      .push      (push_eff[i]),
      .wr_data   (SRAM_RDATA_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (POPEs_in[i]),
      .rd_data   (DATA_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid     (VALIDs_out[i]),
      .full      (FULLs_out[i]),
      .empty     (EMPTYs_out[i]),
      .overflow  (ovf_pulse[i]),
      .underflow (udf_pulse[i])
    );
  end

  // Error flags accumulate any lane's pulse until CLEAR or reset.
  always_comb begin
    ovf_err_d = ovf_err_q;
    udf_err_d = udf_err_q;
    if (CLEAR) begin
      ovf_err_d = 1'b0;
      udf_err_d = 1'b0;
    end else if (!STALL) begin
      ovf_err_d = ovf_err_q | (|ovf_pulse);
      udf_err_d = udf_err_q | (|udf_pulse);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign OVERFLOW_ERR_out  = ovf_err_q;
  assign UNDERFLOW_ERR_out = udf_err_q;

endmodule

// File: tb/tb_opnd_fifo_bank.sv
// Self-checking bench for opnd_fifo_bank (8 lanes, depth 4, read latency 1).
// Each applyStimulus call drives one cycle, derives the expected outputs from
// a queue-based reference FIFO per lane, pushes them to a scoreboard, and
// checkOutput pops and compares them one cycle after the edge.
module tb_opnd_fifo_bank;

  localparam int NL  = 8;
  localparam int DW  = 8;
  localparam int DEP = 4;

  logic              CLK;
  logic              RSTn;
  logic              STALL;
  logic              CLEAR;
  logic [NL*DW-1:0]  SRAM_RDATA_in;
  logic [NL-1:0]     PUSHEs_in;
  logic [NL-1:0]     POPEs_in;
  logic [NL*DW-1:0]  DATA_out;
  logic [NL-1:0]     VALIDs_out;
  logic [NL-1:0]     FULLs_out;
  logic [NL-1:0]     EMPTYs_out;
  logic              OVERFLOW_ERR_out;
  logic              UNDERFLOW_ERR_out;

  opnd_fifo_bank #(
    .NUM_LANES       (NL),
    .DATA_WIDTH      (DW),
    .DEPTH           (DEP),
    .DEPTH_LOG2      (2),
    .SRAM_RD_LATENCY (1)
  ) dut (
    .CLK               (CLK),
    .RSTn              (RSTn),
    .STALL             (STALL),
    .CLEAR             (CLEAR),
    .SRAM_RDATA_in     (SRAM_RDATA_in),
    .PUSHEs_in         (PUSHEs_in),
    .POPEs_in          (POPEs_in),
    .DATA_out          (DATA_out),
    .VALIDs_out        (VALIDs_out),
    .FULLs_out         (FULLs_out),
    .EMPTYs_out        (EMPTYs_out),
    .OVERFLOW_ERR_out  (OVERFLOW_ERR_out),
    .UNDERFLOW_ERR_out (UNDERFLOW_ERR_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NL*DW-1:0] data;
    logic [NL-1:0]    valid;
    logic [NL-1:0]    full;
    logic [NL-1:0]    empty;
    logic             ovf;
    logic             udf;
  } exp_t;

  int               errors;
  int               checks;
  exp_t             cur;
  exp_t             sbq[$];
  logic [DW-1:0]    mq [NL][$];
  logic [NL-1:0]    pendPush;
  logic [NL*DW-1:0] pendData;

  function automatic exp_t resetExp();
    exp_t e;
    e       = '0;
    e.empty = '1;
    return e;
  endfunction

  function automatic logic [NL*DW-1:0] allLanes(input logic [DW-1:0] v);
    return {NL{v}};
  endfunction

  // Lane-distinct row: high nibble = row, low nibble = lane.
  function automatic logic [NL*DW-1:0] laneRow(input int r);
    logic [NL*DW-1:0] d;
    for (int i = 0; i < NL; i++) begin
      d[i*DW +: DW] = DW'((r << 4) | i);
    end
    return d;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed=0 expected=1 entries");
    end else begin
      e = sbq.pop_front();
      checkVal("data",  64'(DATA_out),          64'(e.data));
      checkVal("valid", 64'(VALIDs_out),        64'(e.valid));
      checkVal("full",  64'(FULLs_out),         64'(e.full));
      checkVal("empty", 64'(EMPTYs_out),        64'(e.empty));
      checkVal("ovf",   64'(OVERFLOW_ERR_out),  64'(e.ovf));
      checkVal("udf",   64'(UNDERFLOW_ERR_out), 64'(e.udf));
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NL; i++) mq[i].delete();
    pendPush = '0;
    pendData = '0;
    cur      = resetExp();
  endtask

  // One clock: push issues data for the following cycle's SRAM read.
  task automatic applyStimulus(input logic [NL-1:0] push, input logic [NL-1:0] pop,
                               input logic [NL*DW-1:0] data, input logic stall,
                               input logic clear);
    exp_t nx;
    nx            = cur;
    STALL         = stall;
    CLEAR         = clear;
    PUSHEs_in     = push;
    POPEs_in      = pop;
    SRAM_RDATA_in = pendData;
    if (clear) begin
      resetModel();
      nx = resetExp();
    end else if (!stall) begin
      for (int i = 0; i < NL; i++) begin
        nx.data[i*DW +: DW] = '0;
        nx.valid[i]         = 1'b0;
        if (pop[i]) begin
          if (mq[i].size() > 0) begin
            nx.data[i*DW +: DW] = mq[i].pop_front();
            nx.valid[i]         = 1'b1;
          end else begin
            nx.udf = 1'b1;
          end
        end
        if (pendPush[i]) begin
          if (mq[i].size() < DEP) mq[i].push_back(pendData[i*DW +: DW]);
          else nx.ovf = 1'b1;
        end
        nx.full[i]  = (mq[i].size() == DEP);
        nx.empty[i] = (mq[i].size() == 0);
      end
      pendPush = push;
      pendData = data;
    end
    cur = nx;
    sbq.push_back(nx);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic clearBank();
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [NL-1:0] mask;
    errors        = 0;
    checks        = 0;
    RSTn          = 1'b0;
    STALL         = 1'b0;
    CLEAR         = 1'b0;
    PUSHEs_in     = '0;
    POPEs_in      = '0;
    SRAM_RDATA_in = '0;
    resetModel();

    #12;
    $display("[TB] reset state");
    checkVal("rst_data",  64'(DATA_out),          64'h0);
    checkVal("rst_valid", 64'(VALIDs_out),        64'h0);
    checkVal("rst_full",  64'(FULLs_out),         64'h0);
    checkVal("rst_empty", 64'(EMPTYs_out),        64'hFF);
    checkVal("rst_ovf",   64'(OVERFLOW_ERR_out),  64'h0);
    checkVal("rst_udf",   64'(UNDERFLOW_ERR_out), 64'h0);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] basic ordering");
    for (int k = 0; k < 4; k++) applyStimulus('1, '0, allLanes(DW'(k + 1)), 1'b0, 1'b0);
    idle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus('0, 8'h01, '0, 1'b0, 1'b0);
      checkVal("lane0_order", 64'(DATA_out[DW-1:0]), 64'(k + 1));
    end
    clearBank();

    $display("[TB] skew");
    for (int r = 0; r < 3; r++) applyStimulus('1, '0, laneRow(r + 1), 1'b0, 1'b0);
    idle();
    for (int c = 0; c < NL + 2; c++) begin
      mask = '0;
      for (int i = 0; i < NL; i++) if (c >= i && c < i + 3) mask[i] = 1'b1;
      applyStimulus('0, mask, '0, 1'b0, 1'b0);
      if (c == 5) checkVal("lane5_first", 64'(DATA_out[5*DW +: DW]), 64'h15);
    end
    clearBank();

    $display("[TB] full boundary");
    for (int r = 0; r < 4; r++) applyStimulus('1, '0, laneRow(r + 1), 1'b0, 1'b0);
    applyStimulus('1, '0, laneRow(5), 1'b0, 1'b0);
    checkVal("full_after4", 64'(FULLs_out), 64'hFF);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    checkVal("no_ovf_pushpop", 64'(OVERFLOW_ERR_out), 64'h0);
    for (int k = 0; k < 4; k++) applyStimulus('0, '1, '0, 1'b0, 1'b0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    checkVal("udf_on_empty", 64'(UNDERFLOW_ERR_out), 64'h1);
    clearBank();
    for (int r = 0; r < 5; r++) applyStimulus('1, '0, laneRow(r + 1), 1'b0, 1'b0);
    idle();
    checkVal("ovf_5th_push", 64'(OVERFLOW_ERR_out), 64'h1);
    clearBank();

    $display("[TB] empty boundary");
    applyStimulus('1, '0, laneRow(7), 1'b0, 1'b0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    checkVal("pushpop_empty_cnt1", 64'(EMPTYs_out), 64'h0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    clearBank();

    $display("[TB] stall and clear");
    for (int r = 0; r < 4; r++) applyStimulus('1, '0, laneRow(r + 8), 1'b0, 1'b0);
    idle();
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus('1, '1, laneRow(15), 1'b1, 1'b0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, 1'b1, 1'b1);
    checkVal("clr_stall_empty", 64'(EMPTYs_out), 64'hFF);

    $display("[TB] async reset");
    for (int r = 0; r < 2; r++) applyStimulus('1, '0, laneRow(r + 12), 1'b0, 1'b0);
    idle();
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    #3;
    RSTn = 1'b0;
    #1;
    checkVal("arst_data",  64'(DATA_out),   64'h0);
    checkVal("arst_valid", 64'(VALIDs_out), 64'h0);
    checkVal("arst_empty", 64'(EMPTYs_out), 64'hFF);
    resetModel();
    #2;
    RSTn = 1'b1;
    applyStimulus('1, '0, laneRow(3), 1'b0, 1'b0);
    idle();
    applyStimulus('0, '1, '0, 1'b0, 1'b0);
    checkVal("arst_readback", 64'(DATA_out), 64'(laneRow(3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
